// File: rtl/sync_test_sequencer.sv
// Drives test words through a clock-domain-crossing path under test and checks
// the returned data; handles 2FF (timed), strobe (ack rise) and toggle (any ack edge) handshakes.
module sync_test_sequencer #(
    parameter int unsigned  N       = 8,
    parameter logic [N-1:0] SEED    = N'(8'hA5),
    parameter int unsigned  SETTLE  = 6,
    parameter int unsigned  TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [7:0]   num_words,
    input  logic         ack_async,
    input  logic [N-1:0] rx_data,
    output logic [N-1:0] tx_data,
    output logic         ena_a,
    output logic         req_pulse,
    output logic         busy,
    output logic         done,
    output logic [7:0]   err_cnt,
    output logic         timeout
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ,
        WAIT_ACK,
        CHECK,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_2FF    = 2'b00,
        MODE_PULSE  = 2'b01,
        MODE_TOGGLE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    localparam int unsigned CMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    mode_t         mode_q;
    logic [7:0]    num_q;
    logic [7:0]    idx;
    logic [7:0]    idx_inc;
    logic [N-1:0]  pattern;
    logic [N-1:0]  pattern_inc;
    logic [CW-1:0] wait_cnt;

    logic ack_s1, ack_s2, ack_s3;
    logic ack_rise, ack_any, ack_qual;

    logic run_start, run_empty, wait_clr, wait_inc, check_en, to_set;

    // Only ack_s2/ack_s3 feed the control logic; ack_async never is used raw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
            ack_s3 <= 1'b0;
        end else begin
            ack_s1 <= ack_async;
            ack_s2 <= ack_s1;
            ack_s3 <= ack_s2;
        end
    end

    assign ack_rise    = ack_s2 & ~ack_s3;
    assign ack_any     = ack_s2 ^ ack_s3;
    assign ack_qual    = (mode_q == MODE_PULSE) ? ack_rise : ack_any;
    assign idx_inc     = idx + 8'd1;
    assign pattern_inc = pattern + N'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        run_empty = 1'b0;
        wait_clr  = 1'b0;
        wait_inc  = 1'b0;
        check_en  = 1'b0;
        to_set    = 1'b0;
        ena_a     = 1'b0;
        req_pulse = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mode_t'(mode) != MODE_RSVD && num_words != '0) begin
                        run_start = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        run_empty = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            LOAD: begin
                busy      = 1'b1;
                ena_a     = 1'b1;
                state_nxt = REQ;
            end
            REQ: begin
                busy      = 1'b1;
                req_pulse = (mode_q != MODE_2FF);
                wait_clr  = 1'b1;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                busy = 1'b1;
                if (mode_q == MODE_2FF) begin
                    if (wait_cnt == SETTLE_LAST) state_nxt = CHECK;
                    else                         wait_inc  = 1'b1;
                end else if (ack_qual) begin
                    state_nxt = CHECK;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    to_set    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            CHECK: begin
                busy      = 1'b1;
                check_en  = 1'b1;
                state_nxt = (idx_inc == num_q) ? DONE : LOAD;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_2FF;
            num_q    <= '0;
            idx      <= '0;
            pattern  <= SEED;
            wait_cnt <= '0;
            tx_data  <= '0;
            err_cnt  <= '0;
            timeout  <= 1'b0;
        end else begin
            if (run_start) begin
                mode_q  <= mode_t'(mode);
                num_q   <= num_words;
                idx     <= '0;
                pattern <= SEED;
                tx_data <= SEED;
                err_cnt <= '0;
                timeout <= 1'b0;
            end
            if (run_empty) begin
                err_cnt <= '0;
                timeout <= 1'b0;
            end
            if (wait_clr) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (check_en) begin
                pattern <= pattern_inc;
                idx     <= idx_inc;
                if (rx_data != pattern && err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
                // tx_data is loaded one cycle early so it is valid throughout LOAD.
                if (state_nxt == LOAD) begin
                    tx_data <= pattern_inc;
                end
            end
            if (to_set) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_test_sequencer.sv
// Table-driven bench for sync_test_sequencer plus hand sequences for seed wrap,
// mid-run reset and stray acknowledges.
module tb_sync_test_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [7:0] num_words;
    logic       ack_async;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       ena_a, req_pulse, busy, done, timeout;
    logic [7:0] err_cnt;
    logic       lpbk;

    logic       start2;
    logic [7:0] tx2, err2, rx2;
    logic       ena2, req2, busy2, done2, to2;

    int n_vec  = 0;
    int n_miss = 0;
    int resp_mode = 0;
    int rcnt = 99;

    always #5 clk = ~clk;

    assign rx_data = lpbk ? tx_data : 8'h00;
    assign rx2     = tx2;

    sync_test_sequencer #(.N(8), .SEED(8'hA5), .SETTLE(6), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_words(num_words),
        .ack_async(ack_async), .rx_data(rx_data), .tx_data(tx_data), .ena_a(ena_a),
        .req_pulse(req_pulse), .busy(busy), .done(done), .err_cnt(err_cnt), .timeout(timeout)
    );

    sync_test_sequencer #(.N(8), .SEED(8'hFE), .SETTLE(2), .TIMEOUT(4)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(2'b00), .num_words(8'd4),
        .ack_async(1'b0), .rx_data(rx2), .tx_data(tx2), .ena_a(ena2),
        .req_pulse(req2), .busy(busy2), .done(done2), .err_cnt(err2), .timeout(to2)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] nw;
        int         ack_mode;   // 0 hold, 1 pulse, 2 toggle, 3 drive high, 4 drive low
        bit         loop;
        bit         disturb;
        int         exp_words;
        int         exp_reqs;
        int         exp_err;
        int         exp_to;
        int         exp_cycles;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Far-domain responder: reacts a fixed number of cycles after each req_pulse.
    initial begin
        ack_async = 1'b0;
        forever begin
            @(negedge clk);
            if (req_pulse) rcnt = 0;
            else if (rcnt < 99) rcnt++;
            case (resp_mode)
                1: begin
                    if (rcnt == 4) ack_async = 1'b1;
                    if (rcnt == 7) ack_async = 1'b0;
                end
                2: if (rcnt == 4) ack_async = ~ack_async;
                3: ack_async = 1'b1;
                4: ack_async = 1'b0;
                default: ;
            endcase
        end
    end

    task automatic run_vec(input vec_t v, input int id);
        int n, words, reqs;
        bit got, busy_seen, tx_bad;
        logic [7:0] exp_tx;
        @(posedge clk); #1;
        mode = v.mode; num_words = v.nw; lpbk = v.loop; resp_mode = v.ack_mode; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1; got = 0; words = 0; reqs = 0; busy_seen = 0; tx_bad = 0; exp_tx = 8'hA5;
        while (!got && n < 3000) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                start = 1'b0;
            end else begin
                if (busy) busy_seen = 1;
                if (ena_a) begin
                    words++;
                    if (tx_data !== exp_tx) tx_bad = 1;
                    exp_tx = exp_tx + 8'd1;
                end
                if (req_pulse) reqs++;
                if (v.disturb && busy) begin
                    start = n[0];
                    mode  = 2'b11;
                end
                @(posedge clk);
                n++;
            end
        end
        check($sformatf("v%0d_done_seen", id), int'(got), 1);
        check($sformatf("v%0d_cycles", id), n, v.exp_cycles);
        check($sformatf("v%0d_words", id), words, v.exp_words);
        check($sformatf("v%0d_reqs", id), reqs, v.exp_reqs);
        check($sformatf("v%0d_tx_seq_bad", id), int'(tx_bad), 0);
        check($sformatf("v%0d_busy_seen", id), int'(busy_seen), int'(v.exp_words != 0));
        check($sformatf("v%0d_busy_at_done", id), int'(busy), 0);
        check($sformatf("v%0d_err_cnt", id), int'(err_cnt), v.exp_err);
        check($sformatf("v%0d_timeout", id), int'(timeout), v.exp_to);
        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", id), int'(done), 0);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_err_hold", id), int'(err_cnt), v.exp_err);
        check($sformatf("v%0d_timeout_hold", id), int'(timeout), v.exp_to);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, words, reqs, events;
        logic [7:0] wrap_exp[4];
        vec_t stray;

        vt[0] = '{2'd0, 8'd3,   0, 1'b1, 1'b0,   3, 0,   0, 0,   28};
        vt[1] = '{2'd1, 8'd2,   1, 1'b0, 1'b0,   2, 2,   2, 0,   19};
        vt[2] = '{2'd2, 8'd1,   0, 1'b1, 1'b0,   1, 1,   0, 1,  258};
        vt[3] = '{2'd3, 8'd5,   0, 1'b1, 1'b0,   0, 0,   0, 0,    1};
        vt[4] = '{2'd0, 8'd0,   0, 1'b1, 1'b0,   0, 0,   0, 0,    1};
        vt[5] = '{2'd2, 8'd2,   2, 1'b1, 1'b0,   2, 2,   0, 0,   19};
        vt[6] = '{2'd1, 8'd1,   0, 1'b0, 1'b0,   1, 1,   0, 1,  258};
        vt[7] = '{2'd0, 8'd255, 0, 1'b0, 1'b0, 255, 0, 254, 0, 2296};
        vt[8] = '{2'd0, 8'd2,   0, 1'b0, 1'b1,   2, 0,   2, 0,   19};
        stray = '{2'd1, 8'd1,   3, 1'b1, 1'b0,   1, 1,   0, 1,  258};
        wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 2'b00; num_words = 8'd0; lpbk = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_outputs", int'({ena_a, req_pulse, busy, done, timeout}), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_quiet", int'({ena_a, req_pulse, busy, done, timeout, tx_data, err_cnt}), 0);

        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // Seed FE: pattern must wrap FF -> 00 without a hiccup.
        @(posedge clk); #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 1; words = 0;
        while (!done2 && n < 200) begin
            @(negedge clk);
            if (!done2) begin
                if (ena2) begin
                    if (words < 4) check($sformatf("wrap_tx%0d", words), int'(tx2), int'(wrap_exp[words]));
                    words++;
                end
                @(posedge clk);
                n++;
            end
        end
        check("wrap_cycles", n, 21);
        check("wrap_words", words, 4);
        check("wrap_err_cnt", int'(err2), 0);

        // Reset asserted during WAIT_ACK of the second word.
        @(posedge clk); #1;
        mode = 2'b01; num_words = 8'd3; lpbk = 1'b0; resp_mode = 1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reqs = 0; k = 0;
        while (reqs < 2 && k < 100) begin
            @(negedge clk);
            if (req_pulse) reqs++;
            k++;
        end
        check("rst_reach_word2", reqs, 2);
        @(negedge clk);
        check("pre_rst_err_cnt", int'(err_cnt), 1);
        check("pre_rst_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        resp_mode = 0;
        #1;
        check("midrst_tx_data", int'(tx_data), 0);
        check("midrst_err_cnt", int'(err_cnt), 0);
        check("midrst_outputs", int'({ena_a, req_pulse, busy, done, timeout}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_mode = 3;
        events = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy || ena_a || req_pulse || tx_data != 8'h00) events++;
        end
        check("post_rst_quiet", events, 0);

        // ack is already high: its edge happened outside WAIT_ACK and must not complete the handshake.
        run_vec(stray, 9);
        resp_mode = 4;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
